// File: rtl/matrix_loader_pkg.sv
// Shared coprocessor definitions: opcodes, matrix geometry, FSM states and opcode decode helpers.
// The matrix ALU imports the same package so both sides agree on operand layout.
package matrix_loader_pkg;

    localparam int MEM_AW    = 10;
    localparam int MAT_N     = 5;
    localparam int ELEM_W    = 8;
    localparam int MAT_ELEMS = MAT_N * MAT_N;
    localparam int MAT_W     = MAT_ELEMS * ELEM_W;

    localparam logic [3:0] OP_SOMA    = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_MUL     = 4'b0101;
    localparam logic [3:0] OP_TRANSP  = 4'b0110;
    localparam logic [3:0] OP_OPOSTA  = 4'b0111;
    localparam logic [3:0] OP_ESCALAR = 4'b1000;
    localparam logic [3:0] OP_DET2    = 4'b1001;
    localparam logic [3:0] OP_DET3    = 4'b1010;
    localparam logic [3:0] OP_DET4    = 4'b1011;
    localparam logic [3:0] OP_DET5    = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_VALID  = 3'd4
    } state_t;

    // Only the element-wise binary ops and the matrix product consume operand B.
    function automatic logic needs_b(input logic [3:0] op);
        return (op == OP_SOMA) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    function automatic logic op_supported(input logic [3:0] op);
        return (op >= OP_SOMA) && (op <= OP_DET5);
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Command, memory and ALU-facing signals of the matrix loader.
// master = loader side, slave = the host/memory/ALU environment around it.
interface matrix_loader_if;
    import matrix_loader_pkg::*;

    logic              start;
    logic [3:0]        opcode_in;
    logic [MEM_AW-1:0] addr_a;
    logic [MEM_AW-1:0] addr_b;
    logic [7:0]        escalar_in;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [MAT_W-1:0]  matrizA;
    logic [MAT_W-1:0]  matrizB;
    logic [7:0]        data_escalar;
    logic [3:0]        opcode;
    logic              busy;
    logic              ack;
    logic              erro;

    modport master (
        input  start, opcode_in, addr_a, addr_b, escalar_in, mem_rdata, ack,
        output mem_rd, mem_addr, matrizA, matrizB, data_escalar, opcode, busy, erro
    );

    modport slave (
        output start, opcode_in, addr_a, addr_b, escalar_in, mem_rdata, ack,
        input  mem_rd, mem_addr, matrizA, matrizB, data_escalar, opcode, busy, erro
    );

endinterface

// File: rtl/matrix_loader_shift_reg.sv
// 25-lane byte shift register: new bytes enter the top lane, every lane moves down one per shift,
// so after 25 shifts the first byte captured lands in lane 0 (row-major element 0).
module matrix_shift_reg
    import matrix_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [ELEM_W-1:0] din,
    output logic [MAT_W-1:0]  q
);

    logic [ELEM_W-1:0] r_lane [MAT_ELEMS];

    genvar gi;
    generate
        for (gi = 0; gi < MAT_ELEMS; gi++) begin : g_lane
            logic [ELEM_W-1:0] w_lane_in;

            if (gi == MAT_ELEMS - 1) begin : g_top
                assign w_lane_in = din;
            end else begin : g_inner
                assign w_lane_in = r_lane[gi+1];
            end

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_lane[gi] <= '0;
                end else if (shift_en) begin
                    r_lane[gi] <= w_lane_in;
                end
            end

            assign q[gi*ELEM_W +: ELEM_W] = r_lane[gi];
        end
    endgenerate

endmodule

// File: rtl/matrix_loader.sv
// Matrix coprocessor front end: fetches operand matrices byte-by-byte from synchronous memory,
// presents them with the opcode to the ALU and holds them until the ALU acknowledges.
module matrix_loader
    import matrix_loader_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    matrix_loader_if.master bus
);

    localparam logic [4:0] CNT_LAST = 5'(MAT_ELEMS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_cnt;
    logic [MEM_AW-1:0] r_addr_a;
    logic [MEM_AW-1:0] r_addr_b;
    logic [3:0]        r_opcode;
    logic [7:0]        r_escalar;
    logic              r_erro;
    logic              r_cap_valid;
    logic              r_cap_is_b;

    logic              w_accept;
    logic              w_last;
    logic              w_mem_rd;
    logic [MEM_AW-1:0] w_mem_addr;
    logic              w_busy;
    logic [3:0]        w_opcode_out;

    assign w_accept = (r_state == ST_IDLE) && bus.start && op_supported(bus.opcode_in);
    assign w_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_LOAD_A;
            ST_LOAD_A: if (w_last)   w_state_next = needs_b(r_opcode) ? ST_LOAD_B : ST_DRAIN;
            ST_LOAD_B: if (w_last)   w_state_next = ST_DRAIN;
            ST_DRAIN:                w_state_next = ST_VALID;
            ST_VALID:  if (bus.ack)  w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mem_rd     = 1'b0;
        w_mem_addr   = '0;
        w_busy       = (r_state != ST_IDLE);
        w_opcode_out = 4'b0000;
        case (r_state)
            ST_LOAD_A: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = r_addr_a + MEM_AW'(r_cnt);
            end
            ST_LOAD_B: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = r_addr_b + MEM_AW'(r_cnt);
            end
            ST_VALID:  w_opcode_out = r_opcode;
            default:   ;
        endcase
    end

    // Issue counter, latched command and the one-cycle-delayed capture flag that
    // lines up with the memory's read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_opcode    <= '0;
            r_escalar   <= '0;
            r_erro      <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_is_b  <= 1'b0;
        end else begin
            r_erro      <= (r_state == ST_IDLE) && bus.start && !op_supported(bus.opcode_in);
            r_cap_valid <= w_mem_rd;
            r_cap_is_b  <= (r_state == ST_LOAD_B);
            if (w_accept) begin
                r_cnt     <= '0;
                r_addr_a  <= bus.addr_a;
                r_addr_b  <= bus.addr_b;
                r_opcode  <= bus.opcode_in;
                r_escalar <= bus.escalar_in;
            end else if (w_mem_rd) begin
                r_cnt <= w_last ? '0 : r_cnt + 5'd1;
            end
        end
    end

    matrix_shift_reg u_shift_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_accept),
        .shift_en (r_cap_valid && !r_cap_is_b),
        .din      (bus.mem_rdata),
        .q        (bus.matrizA)
    );

    matrix_shift_reg u_shift_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_accept),
        .shift_en (r_cap_valid && r_cap_is_b),
        .din      (bus.mem_rdata),
        .q        (bus.matrizB)
    );

    assign bus.mem_rd       = w_mem_rd;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.busy         = w_busy;
    assign bus.opcode       = w_opcode_out;
    assign bus.data_escalar = r_escalar;
    assign bus.erro         = r_erro;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: a cycle-level behavioural model checked every cycle,
// plus hand-computed expectations for latency, wrap-around, hold, error and reset behaviour.
module tb_matrix_loader;

    logic clk;
    logic rst;
    matrix_loader_if bus_if ();

    matrix_loader u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide synchronous memory: data appears the cycle after the read request.
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (bus_if.mem_rd) bus_if.mem_rdata <= mem[bus_if.mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int c = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [199:0] build_mat(input int base);
        logic [199:0] r;
        r = '0;
        for (int k = 0; k < 25; k++) r[k*8 +: 8] = mem[(base + k) % 1024];
        return r;
    endfunction

    // Behavioural model: time since the accepted start decides everything.
    bit         m_busy;
    int         m_t;
    int         m_vstart;
    bit         m_nb;
    bit         m_erro;
    logic [3:0] m_op;
    int         m_a;
    int         m_b;
    logic [7:0] m_esc;

    function automatic bit legal_op(input logic [3:0] op);
        return (op >= 4'd3) && (op <= 4'd12);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_erro <= 1'b0;
        end else begin
            m_erro <= !m_busy && bus_if.start && !legal_op(bus_if.opcode_in);
            if (!m_busy) begin
                if (bus_if.start && legal_op(bus_if.opcode_in)) begin
                    m_busy   <= 1'b1;
                    m_t      <= 1;
                    m_op     <= bus_if.opcode_in;
                    m_nb     <= (bus_if.opcode_in <= 4'd5);
                    m_vstart <= (bus_if.opcode_in <= 4'd5) ? 52 : 27;
                    m_a      <= int'(bus_if.addr_a);
                    m_b      <= int'(bus_if.addr_b);
                    m_esc    <= bus_if.escalar_in;
                end
            end else if (m_t >= m_vstart && bus_if.ack) begin
                m_busy <= 1'b0;
                m_t    <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                bit exp_rd;
                bit exp_valid;
                int exp_addr;
                exp_rd    = m_busy && ((m_t >= 1 && m_t <= 25) || (m_nb && m_t >= 26 && m_t <= 50));
                exp_valid = m_busy && (m_t >= m_vstart);
                exp_addr  = (m_t <= 25) ? (m_a + m_t - 1) % 1024 : (m_b + m_t - 26) % 1024;
                chk("model_busy", 200'(bus_if.busy), 200'(m_busy));
                chk("model_mem_rd", 200'(bus_if.mem_rd), 200'(exp_rd));
                if (exp_rd) chk("model_mem_addr", 200'(bus_if.mem_addr), 200'(exp_addr));
                chk("model_opcode", 200'(bus_if.opcode), 200'(exp_valid ? m_op : 4'd0));
                chk("model_erro", 200'(bus_if.erro), 200'(m_erro));
                if (exp_valid) begin
                    chk("model_matrizA", bus_if.matrizA, build_mat(m_a));
                    chk("model_matrizB", bus_if.matrizB, m_nb ? build_mat(m_b) : 200'd0);
                    chk("model_escalar", 200'(bus_if.data_escalar), 200'(m_esc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        c++;
    endtask

    task automatic start_op(input logic [3:0] op, input int a, input int b, input logic [7:0] esc);
        bus_if.opcode_in  = op;
        bus_if.addr_a     = 10'(a);
        bus_if.addr_b     = 10'(b);
        bus_if.escalar_in = esc;
        bus_if.start      = 1'b1;
        c = 0;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_valid(output int vc);
        while (bus_if.opcode == 4'd0 && c < 100) tick();
        vc = c;
    endtask

    task automatic advance_to(input int n);
        while (c < n) tick();
    endtask

    task automatic do_ack();
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
    endtask

    int vc;
    logic [199:0] snap_a;
    logic [199:0] snap_b;
    logic [7:0]   s;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 7 + 3) & 255);
        for (int k = 0; k < 25; k++) begin
            mem[k]         = 8'(k);
            mem[256 + k]   = 8'(100 - k);
        end
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.opcode_in = '0;
        bus_if.addr_a = '0;
        bus_if.addr_b = '0;
        bus_if.escalar_in = '0;
        bus_if.ack = 1'b0;
        tick();
        tick();
        chk("rst_busy", 200'(bus_if.busy), 200'd0);
        chk("rst_mem_rd", 200'(bus_if.mem_rd), 200'd0);
        chk("rst_matrizA", bus_if.matrizA, 200'd0);
        chk("rst_opcode", 200'(bus_if.opcode), 200'd0);
        chk("rst_erro", 200'(bus_if.erro), 200'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Sum: A[k]=k at 0x000, B[k]=100-k at 0x100.
        start_op(4'b0011, 0, 256, 8'h55);
        wait_valid(vc);
        chk("sum_valid_cycle", 200'(vc), 200'd52);
        chk("sum_a_first", 200'(bus_if.matrizA[7:0]), 200'd0);
        chk("sum_a_last", 200'(bus_if.matrizA[199:192]), 200'd24);
        for (int k = 0; k < 25; k++) begin
            s = bus_if.matrizA[k*8 +: 8] + bus_if.matrizB[k*8 +: 8];
            chk("sum_byte", 200'(s), 200'd100);
        end
        $display("txn op=3 valid_cycle=%0d A0=%0d B0=%0d", vc, bus_if.matrizA[7:0], bus_if.matrizB[7:0]);

        // Hold for 10 cycles, then ack together with a start that must be dropped.
        snap_a = bus_if.matrizA;
        snap_b = bus_if.matrizB;
        repeat (10) begin
            tick();
            chk("hold_a", bus_if.matrizA, snap_a);
            chk("hold_b", bus_if.matrizB, snap_b);
            chk("hold_opcode", 200'(bus_if.opcode), 200'd3);
        end
        bus_if.ack = 1'b1;
        bus_if.start = 1'b1;
        bus_if.opcode_in = 4'b0100;
        tick();
        bus_if.ack = 1'b0;
        bus_if.start = 1'b0;
        chk("ack_busy", 200'(bus_if.busy), 200'd0);
        chk("ack_opcode", 200'(bus_if.opcode), 200'd0);
        tick();
        chk("ack_start_dropped", 200'(bus_if.busy), 200'd0);
        $display("txn ack+start: start dropped busy=%0b", bus_if.busy);

        // Transpose with wrapping base address, A only.
        start_op(4'b0110, 10'h3F0, 256, 8'h00);
        chk("tr_addr_c1", 200'(bus_if.mem_addr), 200'h3F0);
        advance_to(17);
        chk("tr_addr_wrap", 200'(bus_if.mem_addr), 200'h000);
        advance_to(25);
        chk("tr_addr_c25", 200'(bus_if.mem_addr), 200'h008);
        advance_to(26);
        chk("tr_rd_c26", 200'(bus_if.mem_rd), 200'd0);
        wait_valid(vc);
        chk("tr_valid_cycle", 200'(vc), 200'd27);
        chk("tr_matrizB", bus_if.matrizB, 200'd0);
        chk("tr_a_first", 200'(bus_if.matrizA[7:0]), 200'h93);
        $display("txn op=6 valid_cycle=%0d A0=%0h", vc, bus_if.matrizA[7:0]);
        do_ack();

        // Illegal opcode.
        start_op(4'b1111, 0, 0, 8'h00);
        chk("ill_erro_c1", 200'(bus_if.erro), 200'd1);
        chk("ill_busy_c1", 200'(bus_if.busy), 200'd0);
        chk("ill_rd_c1", 200'(bus_if.mem_rd), 200'd0);
        tick();
        chk("ill_erro_c2", 200'(bus_if.erro), 200'd0);
        chk("ill_busy_c2", 200'(bus_if.busy), 200'd0);
        $display("txn op=f rejected");

        // Reset in cycle 30 of an A+B load, then a fresh load with swapped bases.
        start_op(4'b0011, 0, 256, 8'h55);
        advance_to(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 200'(bus_if.busy), 200'd0);
        chk("abort_mem_rd", 200'(bus_if.mem_rd), 200'd0);
        chk("abort_mem_addr", 200'(bus_if.mem_addr), 200'd0);
        chk("abort_matrizA", bus_if.matrizA, 200'd0);
        chk("abort_matrizB", bus_if.matrizB, 200'd0);
        chk("abort_escalar", 200'(bus_if.data_escalar), 200'd0);
        chk("abort_opcode", 200'(bus_if.opcode), 200'd0);
        tick();
        start_op(4'b0100, 256, 0, 8'h11);
        wait_valid(vc);
        chk("re_valid_cycle", 200'(vc), 200'd52);
        chk("re_a_first", 200'(bus_if.matrizA[7:0]), 200'd100);
        chk("re_b_last", 200'(bus_if.matrizB[199:192]), 200'd24);
        $display("txn op=4 after abort valid_cycle=%0d A0=%0d", vc, bus_if.matrizA[7:0]);
        do_ack();

        // Scalar op, with a second start during LOAD_A that must be ignored.
        start_op(4'b1000, 256, 0, 8'd3);
        advance_to(5);
        bus_if.start = 1'b1;
        bus_if.opcode_in = 4'b0011;
        tick();
        bus_if.start = 1'b0;
        wait_valid(vc);
        chk("sc_valid_cycle", 200'(vc), 200'd27);
        chk("sc_opcode", 200'(bus_if.opcode), 200'd8);
        repeat (5) begin
            tick();
            chk("sc_escalar", 200'(bus_if.data_escalar), 200'd3);
        end
        $display("txn op=8 valid_cycle=%0d escalar=%0d", vc, bus_if.data_escalar);
        do_ack();
        tick();
        chk("sc_idle_after", 200'(bus_if.busy), 200'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Front-end stage of the matrix coprocessor. On a start command it fetches the operand matrices from byte-wide synchronous memory into two packed 200-bit buses (5x5 signed int8, row-major) and presents them, with the opcode, to the matrix ALU. It holds those operands stable until the ALU acknowledges completion, then returns to idle. Only one operation is in flight at a time.

## Interface

- MEM_AW, 10, memory byte-address width.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high; one clock, reset is synchronous and active-high.
- start  in  1  command strobe; sampled only in IDLE.
- opcode_in  in  4  operation code.
- addr_a  in  MEM_AW  base byte address of matrix A; sampled with start.
- addr_b  in  MEM_AW  base byte address of matrix B; sampled with start.
- escalar_in  in  8  scalar operand; sampled with start.
- mem_rd  out  1  memory read enable.
- mem_addr  out  MEM_AW  memory read address.
- mem_rdata  in  8  read data; valid exactly 1 cycle after the cycle in which mem_rd=1.
- matrizA  out  200  packed A; element (i,j) at bits [(i*5+j)*8 +: 8].
- matrizB  out  200  packed B, same layout.
- data_escalar  out  8  latched scalar.
- opcode  out  4  opcode to the ALU; 4'b0000 except in VALID.
- busy  out  1  high in every state except IDLE.
- ack  in  1  ALU completion (its done); honoured only in VALID.
- erro  out  1  one-cycle pulse: start with an unsupported opcode.

## Operation

- States: IDLE, LOAD_A, LOAD_B, DRAIN, VALID.
- IDLE, start=1:
  - Supported opcodes are 0011..1100. For these, latch opcode, bases and scalar, clear the issue counter, and go to LOAD_A.
  - Any other opcode: stay in IDLE and pulse erro for the next cycle.
- Operand B is needed by opcodes 0011, 0100 and 0101 only.
- LOAD_A: mem_rd=1, mem_addr=addr_a+cnt, cnt counts 0..24.
  - After cnt=24, go to LOAD_B if B is needed, else DRAIN.
  - LOAD_B issues addr_b+0..24 the same way, then goes to DRAIN.
- Capture path:
  - A registered flag records (mem_rd, target) for each issue.
  - On the following cycle, mem_rdata is shifted into the target register.
  - Shift-in is at bits [199:192], and the register shifts right by 8 each capture. After 25 captures, element k sits at bits [k*8 +: 8].
  - The final A capture overlaps the first LOAD_B cycle; this overlap is required, with no bubble.
- DRAIN: one cycle with mem_rd=0, completing the last capture; then go to VALID.
- VALID: drive opcode and hold matrizA, matrizB and data_escalar stable.
  - ack=1 → IDLE; opcode returns to 0000 the next cycle.
  - start is ignored in every non-IDLE state.
- Unused operand: matrizB is cleared to 0 at entry to LOAD_A and stays 0 when B is not loaded.
- Address arithmetic wraps modulo 2^MEM_AW.
- Data is passed through unmodified; the signed interpretation belongs to the ALU.

## Timing

- Cycle 0 is the cycle in which IDLE samples start=1.
- A-only operation:
  - mem_rd high in cycles 1..25.
  - DRAIN in cycle 26.
  - VALID from cycle 27.
- A+B operation:
  - A reads in cycles 1..25, B reads in cycles 26..50.
  - DRAIN in cycle 51.
  - VALID from cycle 52.
- ack sampled high in VALID cycle n → IDLE and opcode=0 in cycle n+1. The earliest next start is accepted in cycle n+1.
- erro is high in cycle 1 only after an illegal start.
- rst values: state IDLE, all outputs 0 (mem_addr 0, matrizA/B 0, opcode 0000, busy 0, erro 0), counter and capture flag cleared.
- rst asserted in any state aborts the operation. A capture pending from the aborted operation is discarded.
- ack=1 and start=1 in the same VALID cycle: ack is honoured, start is dropped.

## Structure

- Shared header coproc_defs.vh holds:
  - opcode localparams (OP_SOMA 0011 … OP_DET5 1100);
  - MAT_N=5, ELEM_W=8, MAT_W=200;
  - the NEEDS_B decode helper.
- The ALU includes the same header.
- One sub-module, matrix_shift_reg: clk, rst, clr, shift_en, din[7:0], q[199:0]. It is instantiated twice, once for A and once for B.
- The FSM, counter and capture flag live in matrix_loader.

## Test plan

- Sum: memory A[k]=k, B[k]=100-k; start with opcode 0011.
  - Expect VALID in cycle 52, every byte of A+B = 100.
  - matrizA[7:0]=0 and matrizA[199:192]=24.
- Transpose, opcode 0110, addr_a=0x3F0 with MEM_AW=10:
  - reads wrap 0x3F0..0x3FF, then 0x000..0x008;
  - matrizB=0;
  - VALID in cycle 27.
- Illegal opcode 1111: erro high in cycle 1 only, busy stays 0, no mem_rd.
- Hold and ack:
  - ack held low for 10 cycles in VALID → outputs unchanged throughout.
  - Then ack=1 together with start=1 → IDLE next cycle, start dropped, opcode=0000.
- Reset: rst in cycle 30 of an A+B load → all outputs 0 in cycle 31.
  - A new start in cycle 32 completes correctly, with no stale bytes.
- Scalar op 1000, escalar_in=3: data_escalar=3 held throughout VALID.
  - A second start arriving during LOAD_A is ignored.
